// File: rtl/uart_pkg.sv
// Shared constants and types for the UART and its baud-rate source.
package uart_pkg;
  localparam int MC_DIV_DEFAULT = 12;
  localparam int SMOD1_DIV      = 16;
  localparam int SMOD0_DIV      = 32;

  typedef logic [7:0] byte_t;
endpackage

// File: rtl/baud_div.sv
// Divides timer overflow pulses into the 16x oversample tick and the 1x baud tick.
module baud_div
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ovf,
  input  logic smod,
  output logic tick_x16,
  output logic tick_baud
);
  localparam logic [4:0] SMOD0_LAST = 5'(SMOD0_DIV - 1);
  localparam logic [3:0] SMOD1_LAST = 4'(SMOD1_DIV - 1);

  logic [4:0] div_cnt;

  // Ticks are decoded from the count before this overflow bumps it.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      tick_x16  <= 1'b0;
      tick_baud <= 1'b0;
    end else begin
      tick_x16  <= ovf && (smod || div_cnt[0]);
      tick_baud <= ovf && (smod ? (div_cnt[3:0] == SMOD1_LAST)
                                : (div_cnt == SMOD0_LAST));
      if (ovf) div_cnt <= div_cnt + 5'd1;
    end
  end
endmodule

// File: rtl/uart_baud_timer1.sv
// 8051 Timer 1, mode 2 (8-bit auto-reload), acting as the serial-port baud source.
module uart_baud_timer1
  import uart_pkg::*;
#(
  parameter int CLK_DIV = MC_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tr1,
  input  logic       smod,
  input  logic       th1_we,
  input  logic       tl1_we,
  input  logic [7:0] wdata,
  input  logic       tf1_clr,
  output logic [7:0] th1,
  output logic [7:0] tl1,
  output logic       tf1,
  output logic       tick_x16,
  output logic       tick_baud
);
  localparam int              MC_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(CLK_DIV - 1);

  logic [MC_W-1:0] mc_cnt;
  logic            mc_tick;
  byte_t           th1_q;
  byte_t           tl1_q;
  logic            ovf;
  logic            tf1_q;

  assign mc_tick = (mc_cnt == MC_LAST) && tr1;

  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // this is what makes a same-cycle TH1 write leave the reload on the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      mc_cnt <= '0;
    end else if (tr1) begin
      mc_cnt <= (mc_cnt == MC_LAST) ? '0 : mc_cnt + MC_W'(1);
    end
  end

  // A TL1 write overrides both increment and reload, and suppresses the overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      th1_q <= '0;
      tl1_q <= '0;
      ovf   <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (th1_we) th1_q <= wdata;
      if (tl1_we) begin
        tl1_q <= wdata;
      end else if (mc_tick) begin
        if (tl1_q == 8'hFF) begin
          tl1_q <= th1_q;
          ovf   <= 1'b1;
        end else begin
          tl1_q <= tl1_q + 8'd1;
        end
      end
    end
  end

  // Setting wins over a coincident software clear so no overflow is lost.
  always_ff @(posedge clk) begin
    if (rst)          tf1_q <= 1'b0;
    else if (ovf)     tf1_q <= 1'b1;
    else if (tf1_clr) tf1_q <= 1'b0;
  end

  baud_div u_baud_div (
    .clk       (clk),
    .rst       (rst),
    .ovf       (ovf),
    .smod      (smod),
    .tick_x16  (tick_x16),
    .tick_baud (tick_baud)
  );

  assign th1 = th1_q;
  assign tl1 = tl1_q;
  assign tf1 = tf1_q;
endmodule

// File: tb/tb_uart_baud_timer1.sv
// Self-checking bench for uart_baud_timer1: tick-time scoreboard plus a UART loopback.
module tb_uart_baud_timer1;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tr1 = 1'b0;
  logic       smod = 1'b0;
  logic       th1_we = 1'b0;
  logic       tl1_we = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       tf1_clr = 1'b0;
  logic [7:0] th1;
  logic [7:0] tl1;
  logic       tf1;
  logic       tick_x16;
  logic       tick_baud;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int qx[$];
  int qb[$];

  uart_baud_timer1 #(.CLK_DIV(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .tr1       (tr1),
    .smod      (smod),
    .th1_we    (th1_we),
    .tl1_we    (tl1_we),
    .wdata     (wdata),
    .tf1_clr   (tf1_clr),
    .th1       (th1),
    .tl1       (tl1),
    .tf1       (tf1),
    .tick_x16  (tick_x16),
    .tick_baud (tick_baud)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Scoreboard: every tick must arrive exactly at the cycle queued for it.
  always @(negedge clk) begin
    if (tick_x16) begin
      if (qx.size() == 0) check("x16_unexpected", cyc, -1);
      else                check("x16_time", cyc, qx.pop_front());
    end
    if (tick_baud) begin
      if (qb.size() == 0) check("baud_unexpected", cyc, -1);
      else                check("baud_time", cyc, qb.pop_front());
    end
  end

  // Loopback: mode-1 transmitter clocked by tick_baud, receiver oversampling on tick_x16.
  logic       lb_en = 1'b0;
  logic       txd = 1'b1;
  logic [9:0] tx_sh = '1;
  int         tx_left = 0;
  int         rx_state = 0;
  int         rx_cnt = 0;
  int         rx_bit = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_data = '0;
  int         rx_done_cnt = 0;

  always @(negedge clk) begin
    if (lb_en && tick_baud && tx_left > 0) begin
      txd = tx_sh[0];
      tx_sh = {1'b1, tx_sh[9:1]};
      tx_left--;
    end
    if (lb_en && tick_x16) begin
      case (rx_state)
        0: if (!txd) begin rx_state = 1; rx_cnt = 0; end
        1: begin
          rx_cnt++;
          if (rx_cnt == 8) begin
            rx_cnt = 0; rx_bit = 0;
            rx_state = txd ? 0 : 2;
          end
        end
        default: begin
          rx_cnt++;
          if (rx_cnt == 16) begin
            rx_cnt = 0;
            if (rx_bit < 8) begin
              rx_sh = {txd, rx_sh[7:1]};
              rx_bit++;
            end else begin
              if (txd) begin rx_data = rx_sh; rx_done_cnt++; end
              rx_state = 0;
            end
          end
        end
      endcase
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Called on a negedge; reset is sampled at the next edge and outputs checked after it.
  task automatic apply_reset();
    rst = 1'b1; tr1 = 1'b0; th1_we = 1'b0; tl1_we = 1'b0; tf1_clr = 1'b0;
    @(negedge clk);
    check("rst_th1", int'(th1), 0);
    check("rst_tl1", int'(tl1), 0);
    check("rst_tf1", int'(tf1), 0);
    check("rst_tick_x16", int'(tick_x16), 0);
    check("rst_tick_baud", int'(tick_baud), 0);
    rst = 1'b0;
  endtask

  task automatic program_run(input logic [7:0] th, input logic [7:0] tl, input logic sm,
                             output int t0);
    th1_we = 1'b1; wdata = th;
    @(negedge clk);
    th1_we = 1'b0; tl1_we = 1'b1; wdata = tl;
    @(negedge clk);
    tl1_we = 1'b0; smod = sm;
    @(negedge clk);
    check("prog_th1", int'(th1), int'(th));
    check("prog_tl1", int'(tl1), int'(tl));
    tr1 = 1'b1;
    t0 = cyc;
  endtask

  // Expected tick cycles for n overflows spaced per clocks apart, starting from a fresh divider.
  task automatic push_run(input int t0, input int per, input logic sm, input int n);
    for (int k = 1; k <= n; k++) begin
      int d;
      d = (k - 1) % 32;
      if (sm || (d % 2 == 1)) qx.push_back(t0 + k * per + 1);
      if (sm ? (d % 16 == 15) : (d == 31)) qb.push_back(t0 + k * per + 1);
    end
  endtask

  task automatic end_phase(input string tag);
    check({tag, "_x16_missing"}, qx.size(), 0);
    check({tag, "_baud_missing"}, qb.size(), 0);
    qx.delete();
    qb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    @(negedge clk);
    apply_reset();

    // 9600 baud: th1=FD, smod=0; then reset with a tick_baud pending.
    program_run(8'hFD, 8'hFD, 1'b0, t0);
    push_run(t0, 36, 1'b0, 95);
    wait_cyc(t0 + 11);  check("s1_tl1_fd",   int'(tl1), 'hFD);
    wait_cyc(t0 + 12);  check("s1_tl1_fe",   int'(tl1), 'hFE);
    wait_cyc(t0 + 24);  check("s1_tl1_ff",   int'(tl1), 'hFF);
    wait_cyc(t0 + 36);  check("s1_tl1_rld",  int'(tl1), 'hFD);
    wait_cyc(t0 + 3456);
    end_phase("s1");
    apply_reset();

    // Re-programmed run: first tick_baud a full 32 overflows later.
    program_run(8'hFD, 8'hFD, 1'b0, t0);
    push_run(t0, 36, 1'b0, 32);
    wait_cyc(t0 + 1160);
    end_phase("s1b");
    apply_reset();

    // 19200 baud: smod=1, plus TF1 set/clear behaviour.
    program_run(8'hFD, 8'hFD, 1'b1, t0);
    push_run(t0, 36, 1'b1, 32);
    wait_cyc(t0 + 36);  check("s2_tf1_before", int'(tf1), 0);
    wait_cyc(t0 + 37);  check("s2_tf1_set",    int'(tf1), 1);
    wait_cyc(t0 + 40);  tf1_clr = 1'b1;
    wait_cyc(t0 + 41);  tf1_clr = 1'b0; check("s2_tf1_clr", int'(tf1), 0);
    wait_cyc(t0 + 72);  tf1_clr = 1'b1;
    wait_cyc(t0 + 73);  tf1_clr = 1'b0; check("s2_tf1_set_wins", int'(tf1), 1);
    wait_cyc(t0 + 1160);
    end_phase("s2");
    apply_reset();

    // th1=FF: overflow every machine cycle; tr1 freeze and resume.
    program_run(8'hFF, 8'hFF, 1'b1, t0);
    qx.push_back(t0 + 13);
    qx.push_back(t0 + 25);
    qx.push_back(t0 + 87);
    qx.push_back(t0 + 99);
    wait_cyc(t0 + 30);  tr1 = 1'b0;
    wait_cyc(t0 + 50);  check("s3_tl1_frozen", int'(tl1), 'hFF);
    wait_cyc(t0 + 80);  tr1 = 1'b1;
    wait_cyc(t0 + 105);
    end_phase("s3");
    apply_reset();

    // TL1 write on a wrap cycle; TH1 write on a reload cycle.
    program_run(8'hFD, 8'hFD, 1'b1, t0);
    qx.push_back(t0 + 49);
    qx.push_back(t0 + 85);
    wait_cyc(t0 + 35);  tl1_we = 1'b1; wdata = 8'h10;
    wait_cyc(t0 + 36);  tl1_we = 1'b0; check("s4_tl1_wr_wins", int'(tl1), 'h10);
    wait_cyc(t0 + 37);  check("s4_tf1_unchanged", int'(tf1), 0);
    wait_cyc(t0 + 40);  tl1_we = 1'b1; wdata = 8'hFF;
    wait_cyc(t0 + 41);  tl1_we = 1'b0;
    wait_cyc(t0 + 47);  th1_we = 1'b1; wdata = 8'h80; check("s4_tl1_pre", int'(tl1), 'hFF);
    wait_cyc(t0 + 48);  th1_we = 1'b0;
    check("s4_reload_old_th1", int'(tl1), 'hFD);
    check("s4_th1_new", int'(th1), 'h80);
    wait_cyc(t0 + 84);  check("s4_reload_new_th1", int'(tl1), 'h80);
    wait_cyc(t0 + 90);
    end_phase("s4");
    apply_reset();

    // Loopback: send 8'hA5 framed by tick_baud, receive with tick_x16 oversampling.
    tx_sh = {1'b1, 8'hA5, 1'b0};
    tx_left = 10;
    lb_en = 1'b1;
    program_run(8'hFF, 8'hFF, 1'b1, t0);
    push_run(t0, 12, 1'b1, 191);
    wait_cyc(t0 + 2300);
    check("lb_tx_done", tx_left, 0);
    check("lb_rx_done_count", rx_done_cnt, 1);
    check("lb_rx_data", int'(rx_data), 'hA5);
    end_phase("lb");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
